// File: rtl/mux_scan_arb.sv
// mux_scan_arb: round-robin scanning arbiter for an 8:1 selector.
// Four-phase sequence per grant: IDLE -> SETUP -> GRANT -> RELEASE.
// Every output is a flop decoded from the next-state values, so no input
// reaches an output combinationally.
// Optional feature: define MUX_ARB_TIMEOUT_EN to add the hold counter.
// With the counter present, a GRANT ends after HOLD_MAX cycles.
module mux_scan_arb #(
  parameter int HOLD_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [2:0] SEL,
  output logic       CE_N,
  output logic [7:0] GNT,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // The hold counter is 8 bits wide, so HOLD_MAX must lie in the range 1..255.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_illegal
    $error("mux_scan_arb: HOLD_MAX must be within 1..255");
  end

  logic [1:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic       ce_n_q, ce_n_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic [7:0] rot_req;
  logic [2:0] pick_off;
  logic [2:0] pick_sel;
  logic       hold_hit;

  // Rotate the request vector so that bit 0 is requester PTR+1.
  // Bit 7 is PTR itself, which therefore has the lowest priority.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_rot
    assign rot_req[gi] = REQ[ptr_q + 3'(gi + 1)];
  end

  // Find the lowest set bit of the rotated vector.
  // The loop runs downwards so that the smallest offset is assigned last.
  always_comb begin
    pick_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) pick_off = 3'(i);
    end
    pick_sel = ptr_q + pick_off + 3'd1;
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_hit = (hold_q == 8'(HOLD_MAX));

  // The hold count is 1 in the first GRANT cycle and rises by one each GRANT cycle.
  // RELEASE clears it.
  always_comb begin
    hold_d = hold_q;
    case (state_q)
      ST_SETUP:   hold_d = 8'd1;
      ST_GRANT:   hold_d = hold_q + 8'd1;
      ST_RELEASE: hold_d = 8'd0;
      default:    hold_d = hold_q;
    endcase
  end

  // Hold counter register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) hold_q <= 8'd0;
    else          hold_q <= hold_d;
  end
`else
  assign hold_hit = 1'b0;
`endif

  // Next-state logic.
  // SEL is loaded only when leaving IDLE. PTR is loaded only in RELEASE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          sel_d   = pick_sel;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:   state_d = ST_GRANT;
      ST_GRANT: begin
        if (DONE || !REQ[sel_q] || hold_hit) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        ptr_d   = sel_q;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Decode the outputs from the next state so that they are registered
  // and still line up with the state they describe.
  always_comb begin
    ce_n_d = (state_d != ST_GRANT);
    gnt_d  = (state_d == ST_GRANT) ? (8'd1 << sel_d) : 8'd0;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  // Reset is asynchronous, so CE_N rises as soon as RESET_N falls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      ce_n_q  <= 1'b1;
      gnt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ce_n_q  <= ce_n_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign SEL  = sel_q;
  assign CE_N = ce_n_q;
  assign GNT  = gnt_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_mux_scan_arb.sv
// Testbench for mux_scan_arb.
// The main part is a per-cycle vector table. Hand-written sequences then cover
// the FF wrap, the hold timeout and an asynchronous reset during GRANT.
module tb_mux_scan_arb;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [7:0] REQ = 8'h00;
  logic       DONE = 1'b0;
  logic [2:0] SEL;
  logic       CE_N;
  logic [7:0] GNT;
  logic       BUSY;

  int n_cmp = 0;
  int n_fail = 0;

  mux_scan_arb #(.HOLD_MAX(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .DONE(DONE),
    .SEL(SEL), .CE_N(CE_N), .GNT(GNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       ce_n;
    logic [7:0] gnt;
    logic       busy;
  } vec_t;

  vec_t vecs [37];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the inputs, clock one edge, then check the invariants 1 ns after the edge.
  task automatic step(input logic [7:0] r, input logic d);
    REQ = r;
    DONE = d;
    @(posedge CLK);
    #1;
    check("ce_gnt_coincide", 32'((CE_N == 1'b0) == (GNT != 8'h00)), 32'd1);
    check("gnt_onehot", 32'($countones(GNT) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    REQ = 8'h00;
    DONE = 1'b0;
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Step with the current inputs until CE_N goes low. Give up after 12 cycles.
  task automatic wait_grant(input logic [2:0] exp_sel, input string name, output int cycles);
    cycles = 0;
    while (CE_N !== 1'b0 && cycles < 12) begin
      step(REQ, DONE);
      cycles++;
    end
    check({name, "_granted"}, 32'(CE_N), 32'd0);
    check({name, "_sel"}, 32'(SEL), 32'(exp_sel));
    check({name, "_gnt"}, 32'(GNT), 32'(8'd1 << exp_sel));
    $display("grant %s: SEL=%0d GNT=%02h after %0d cycles", name, SEL, GNT, cycles);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int low;
    int high;
    int guard;
    logic [2:0] exp_sel;

    // Fields: req, done, sel, ce_n, gnt, busy. Expected outputs are taken 1 ns after each edge.
    vecs[0]  = '{8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{8'h24, 1'b0, 3'd2, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{8'h24, 1'b0, 3'd2, 1'b0, 8'h04, 1'b1};
    vecs[4]  = '{8'h24, 1'b0, 3'd2, 1'b0, 8'h04, 1'b1};
    vecs[5]  = '{8'h24, 1'b1, 3'd2, 1'b1, 8'h00, 1'b1};
    vecs[6]  = '{8'h24, 1'b0, 3'd2, 1'b1, 8'h00, 1'b0};
    vecs[7]  = '{8'h24, 1'b0, 3'd5, 1'b1, 8'h00, 1'b1};
    vecs[8]  = '{8'h24, 1'b0, 3'd5, 1'b0, 8'h20, 1'b1};
    vecs[9]  = '{8'h24, 1'b1, 3'd5, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{8'h24, 1'b0, 3'd5, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{8'h24, 1'b0, 3'd2, 1'b1, 8'h00, 1'b1};
    vecs[12] = '{8'h24, 1'b0, 3'd2, 1'b0, 8'h04, 1'b1};
    vecs[13] = '{8'h24, 1'b1, 3'd2, 1'b1, 8'h00, 1'b1};
    vecs[14] = '{8'h24, 1'b0, 3'd2, 1'b1, 8'h00, 1'b0};
    vecs[15] = '{8'h24, 1'b0, 3'd5, 1'b1, 8'h00, 1'b1};
    vecs[16] = '{8'h24, 1'b0, 3'd5, 1'b0, 8'h20, 1'b1};
    vecs[17] = '{8'h24, 1'b1, 3'd5, 1'b1, 8'h00, 1'b1};
    vecs[18] = '{8'h08, 1'b0, 3'd5, 1'b1, 8'h00, 1'b0};
    vecs[19] = '{8'h08, 1'b0, 3'd3, 1'b1, 8'h00, 1'b1};
    vecs[20] = '{8'h00, 1'b0, 3'd3, 1'b0, 8'h08, 1'b1};
    vecs[21] = '{8'h00, 1'b0, 3'd3, 1'b1, 8'h00, 1'b1};
    vecs[22] = '{8'h00, 1'b0, 3'd3, 1'b1, 8'h00, 1'b0};
    vecs[23] = '{8'h00, 1'b0, 3'd3, 1'b1, 8'h00, 1'b0};
    vecs[24] = '{8'h10, 1'b0, 3'd4, 1'b1, 8'h00, 1'b1};
    vecs[25] = '{8'h11, 1'b0, 3'd4, 1'b0, 8'h10, 1'b1};
    vecs[26] = '{8'h01, 1'b0, 3'd4, 1'b1, 8'h00, 1'b1};
    vecs[27] = '{8'h01, 1'b0, 3'd4, 1'b1, 8'h00, 1'b0};
    vecs[28] = '{8'h01, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1};
    vecs[29] = '{8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1};
    vecs[30] = '{8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1};
    vecs[31] = '{8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1};
    vecs[32] = '{8'h01, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
    vecs[33] = '{8'h01, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1};
    vecs[34] = '{8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1};
    vecs[35] = '{8'h01, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1};
    vecs[36] = '{8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};

    // Reset: the outputs must take their reset values without a clock edge.
    #2;
    RESET_N = 1'b0;
    #1;
    check("rst_sel", 32'(SEL), 32'd0);
    check("rst_ce_n", 32'(CE_N), 32'd1);
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Per-cycle vector table.
    for (int i = 0; i < 37; i++) begin
      step(vecs[i].req, vecs[i].done);
      $display("vec %0d: REQ=%02h DONE=%0d -> SEL=%0d CE_N=%0d GNT=%02h BUSY=%0d",
               i, vecs[i].req, vecs[i].done, SEL, CE_N, GNT, BUSY);
      check($sformatf("vec%0d_sel", i), 32'(SEL), 32'(vecs[i].sel));
      check($sformatf("vec%0d_ce_n", i), 32'(CE_N), 32'(vecs[i].ce_n));
      check($sformatf("vec%0d_gnt", i), 32'(GNT), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(vecs[i].busy));
    end

    // REQ=FF with one DONE per grant: the grants must wrap 0..7 and return to 0.
    do_reset();
    REQ = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_sel = 3'(k % 8);
      wait_grant(exp_sel, $sformatf("ff%0d", k), cyc);
      check($sformatf("ff%0d_latency", k), 32'(cyc), 32'd2);
      step(8'hFF, 1'b1);
      check($sformatf("ff%0d_release", k), 32'(CE_N), 32'd1);
      step(8'hFF, 1'b0);
      check($sformatf("ff%0d_idle_busy", k), 32'(BUSY), 32'd0);
    end

    // A single requester that never asserts DONE.
    do_reset();
    REQ = 8'h01;
    wait_grant(3'd0, "hold", cyc);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      low = 1;
      guard = 0;
      step(8'h01, 1'b0);
      while (CE_N == 1'b0 && guard < 20) begin
        low++;
        guard++;
        step(8'h01, 1'b0);
      end
      check($sformatf("timeout%0d_low_cycles", r), 32'(low), 32'd4);
      high = 1;
      guard = 0;
      step(8'h01, 1'b0);
      while (CE_N == 1'b1 && guard < 20) begin
        high++;
        guard++;
        step(8'h01, 1'b0);
      end
      check($sformatf("timeout%0d_high_cycles", r), 32'(high), 32'd3);
      $display("timeout round %0d: low=%0d high=%0d", r, low, high);
    end
`else
    for (int r = 0; r < 20; r++) begin
      step(8'h01, 1'b0);
      check($sformatf("nohold%0d_ce_n", r), 32'(CE_N), 32'd0);
    end
    $display("hold without timeout: CE_N=%0d after 20 cycles", CE_N);
`endif

    // Assert reset during the GRANT of SEL=6. CE_N must rise with no clock edge.
    do_reset();
    REQ = 8'h40;
    wait_grant(3'd6, "pre_rst", cyc);
    step(8'h40, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst_ce_n", 32'(CE_N), 32'd1);
    check("async_rst_gnt", 32'(GNT), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    check("async_rst_sel", 32'(SEL), 32'd0);
    RESET_N = 1'b1;
    wait_grant(3'd6, "post_rst", cyc);
    check("post_rst_latency", 32'(cyc), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_arb.md
MUX_SCAN_ARB -- requirements
Module: mux_scan_arb

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, maximum GRANT-state cycles per grant (legal 1..255).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port REQ  input  8  per-requester request, bit n = mux input In.
REQ-005 SHALL have port DONE  input  1  granted requester finished; sampled only in GRANT.
REQ-006 SHALL have port SEL  output  3  select code driven to the 8:1 selector (SEL[0]=SEL0).
REQ-007 SHALL have port CE_N  output  1  selector strobe, active-low; low only in GRANT.
REQ-008 SHALL have port GNT  output  8  one-hot grant, bit SEL set only in GRANT.
REQ-009 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-010 SHALL register all outputs; no combinational path from inputs to outputs.

Function
REQ-011 SHALL implement states IDLE, SETUP, GRANT, RELEASE.
REQ-012 IDLE: CE_N=1, GNT=0; if REQ!=0, SHALL load SEL with the first set REQ bit searching upward from PTR+1 modulo 8, then go to SETUP.
REQ-013 Search wrap: PTR=7 SHALL search 0,1,...,7; PTR's own bit SHALL be selectable last (single requester regrants itself).
REQ-014 SETUP: exactly one cycle, CE_N=1, GNT=0, SEL stable; SHALL go to GRANT unconditionally (select settle time).
REQ-015 GRANT: CE_N=0, GNT=1<<SEL, hold counter increments each cycle starting from 1.
REQ-016 GRANT SHALL exit to RELEASE on DONE=1, or REQ[SEL]=0, or hold counter = HOLD_MAX (timeout build only); priority irrelevant, all yield RELEASE.
REQ-017 RELEASE: exactly one cycle, CE_N=1, GNT=0; PTR<=SEL; hold counter<=0; SHALL go to IDLE.
REQ-018 Grant latency: REQ rising in IDLE at edge k SHALL give CE_N=0 after edge k+2.
REQ-019 SEL SHALL change only on the IDLE->SETUP transition; SEL holds through SETUP, GRANT, RELEASE.
REQ-020 REQ changes on non-granted bits during SETUP/GRANT/RELEASE SHALL have no effect until next IDLE.
REQ-021 REQ[SEL] dropping during SETUP SHALL NOT abort; GRANT then exits after one cycle.
REQ-022 CE_N low and GNT nonzero SHALL always coincide; GNT SHALL never have more than one bit set.
REQ-023 Minimum turnaround between grants SHALL be 3 cycles (RELEASE, IDLE, SETUP).

Reset
REQ-024 RESET_N low SHALL immediately force state IDLE, SEL=0, CE_N=1, GNT=0, BUSY=0, PTR=7, hold counter=0.
REQ-025 Reset asserted mid-GRANT SHALL drop CE_N high without waiting for a clock edge.
REQ-026 First grant after reset SHALL go to lowest set REQ bit (PTR=7 reset value).

Configuration
REQ-027 Macro MUX_ARB_TIMEOUT_EN defined: hold counter and HOLD_MAX exit SHALL be present.
REQ-028 MUX_ARB_TIMEOUT_EN undefined: no hold counter; GRANT SHALL persist until DONE or REQ[SEL]=0; HOLD_MAX ignored.

Verification
REQ-029 Reset, REQ=8'h00 -> SEL=0, CE_N=1, GNT=0, BUSY=0 indefinitely.
REQ-030 After reset, REQ=8'h24 held, DONE pulsed once per grant -> grant order SEL=2,5,2,5; CE_N low 2 cycles after IDLE exit each time.
REQ-031 REQ=8'hFF, DONE each grant -> SEL sequence 0,1,...,7,0 (wrap), GNT always one-hot.
REQ-032 Timeout build, HOLD_MAX=4, REQ=8'h01, DONE=0 -> CE_N low exactly 4 cycles, 3 cycles high, repeat; non-timeout build -> CE_N stays low.
REQ-033 RESET_N pulsed low mid-GRANT of SEL=6 -> CE_N=1, GNT=0 asynchronously; next grant with REQ=8'h40 is SEL=6.
REQ-034 Grant on SEL=3, REQ drops to 8'h00 -> RELEASE next cycle, then IDLE, BUSY=0.
